information_demapper: RTL and testbench

Inverse of the information mapper; sits on the receive side between the mapped-word FIFO and the information-data FIFO.
- Each accepted cycle pops one mapped word and its mapping indicators.
- Extracts the bits whose indicator is 1, in LSB-first order.
- Packs them contiguously into an accumulator and writes full MAPPER_PARALLELISM-bit information words to the output FIFO.
- A flush request drains the accumulator, emitting a zero-padded final partial word.

---
 rtl/information_mapper_pkg.sv | 19 +
 rtl/information_demapper_if.sv | 44 ++++
 rtl/info_bit_compactor.sv | 32 +++
 rtl/information_demapper.sv | 125 ++++++++++++
 tb/tb_information_demapper.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/information_mapper_pkg.sv
// Shared definitions for the information mapper / demapper pair.
//   DEFAULT_MAPPER_PARALLELISM : default width of mapped, indicator and info words
//   cnt_width()                : bit count needed for an accumulator fill of 0..2P-1
//   demap_state_e              : demapper control states
package information_mapper_pkg;

  localparam int unsigned DEFAULT_MAPPER_PARALLELISM = 8;

  // Width of a counter able to hold 0..2p-1.
  function automatic int unsigned cnt_width(input int unsigned p);
    return $clog2(2 * p);
  endfunction

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } demap_state_e;

endpackage

// File: rtl/information_demapper_if.sv
// Bus bundle between the demapper and its surrounding FIFOs.
//   mapped_in_fifo_*      : show-ahead mapped-word FIFO read side plus indicators
//   data_out_fifo_*       : information-word FIFO write side
//   flush / flush_done    : end-of-frame request and completion pulse
// modport master : the demapper; modport slave : the FIFO / frame-control side.
interface information_demapper_if #(
  parameter int unsigned MAPPER_PARALLELISM = information_mapper_pkg::DEFAULT_MAPPER_PARALLELISM
);

  logic [MAPPER_PARALLELISM-1:0] mapped_in_fifo_rd_data;
  logic [MAPPER_PARALLELISM-1:0] mapping_indicators;
  logic                          mapped_in_fifo_empty;
  logic                          mapped_in_fifo_rd_req;
  logic                          data_out_fifo_full;
  logic                          data_out_fifo_wr_req;
  logic [MAPPER_PARALLELISM-1:0] data_out_fifo_wr_data;
  logic                          flush;
  logic                          flush_done;

  modport master (
    input  mapped_in_fifo_rd_data,
    input  mapping_indicators,
    input  mapped_in_fifo_empty,
    output mapped_in_fifo_rd_req,
    input  data_out_fifo_full,
    output data_out_fifo_wr_req,
    output data_out_fifo_wr_data,
    input  flush,
    output flush_done
  );

  modport slave (
    output mapped_in_fifo_rd_data,
    output mapping_indicators,
    output mapped_in_fifo_empty,
    input  mapped_in_fifo_rd_req,
    output data_out_fifo_full,
    input  data_out_fifo_wr_req,
    input  data_out_fifo_wr_data,
    output flush,
    input  flush_done
  );

endinterface

// File: rtl/info_bit_compactor.sv
// Combinational bit compactor: gathers the data bits whose indicator is set,
// LSB first, into a contiguous word starting at bit 0.
//   data_i : mapped word
//   ind_i  : indicator word (1 = information bit)
//   c_o    : compacted bits, zero above k_o-1
//   k_o    : number of selected bits (popcount of ind_i)
module info_bit_compactor #(
  parameter  int unsigned P  = 8,
  localparam int unsigned KW = $clog2(P + 1)
) (
  input  logic [P-1:0]  data_i,
  input  logic [P-1:0]  ind_i,
  output logic [P-1:0]  c_o,
  output logic [KW-1:0] k_o
);

  logic [KW-1:0] n_v;

  // Running fill position; each selected bit lands at the next free slot.
  always_comb begin
    c_o = '0;
    n_v = '0;
    for (int i = 0; i < int'(P); i++) begin
      if (ind_i[i]) begin
        c_o = c_o | (P'(data_i[i]) << n_v);
        n_v = n_v + KW'(1);
      end
    end
    k_o = n_v;
  end

endmodule

// File: rtl/information_demapper.sv
// Receive-side information demapper. Pops mapped words with their indicators,
// keeps only the information bits, packs them into an accumulator and writes
// full information words to the output FIFO. A flush drains the remainder as a
// zero-padded word and then pulses flush_done.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : FIFO handshakes and flush control (master side)
module information_demapper
  import information_mapper_pkg::*;
#(
  parameter int unsigned MAPPER_PARALLELISM = DEFAULT_MAPPER_PARALLELISM
) (
  input logic                    clk,
  input logic                    reset,
  information_demapper_if.master bus
);

  localparam int unsigned P  = MAPPER_PARALLELISM;
  localparam int unsigned AW = 2 * P;
  localparam int unsigned CW = cnt_width(P);
  localparam int unsigned KW = $clog2(P + 1);

  localparam logic [0:0] S_RUN   = ST_RUN;
  localparam logic [0:0] S_FLUSH = ST_FLUSH;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_req_q, wr_req_d;
  logic [P-1:0]  wr_data_q, wr_data_d;
  logic          flush_done_q, flush_done_d;

  logic [P-1:0]  comp_c;
  logic [KW-1:0] comp_k;

  logic          have_word_c;
  logic          emit_c;
  logic          flush_emit_c;
  logic          accept_c;
  logic [AW-1:0] acc_e;
  logic [CW-1:0] cnt_e;

  info_bit_compactor #(.P(P)) u_compactor (
    .data_i (bus.mapped_in_fifo_rd_data),
    .ind_i  (bus.mapping_indicators),
    .c_o    (comp_c),
    .k_o    (comp_k)
  );

  // Handshake decisions for the current cycle.
  always_comb begin
    have_word_c  = (cnt_q >= CW'(P));
    emit_c       = have_word_c && !bus.data_out_fifo_full;
    flush_emit_c = (state_q == S_FLUSH) && !have_word_c && (cnt_q != '0)
                   && !bus.data_out_fifo_full;
    accept_c     = reset && (state_q == S_RUN) && !bus.mapped_in_fifo_empty
                   && (!have_word_c || emit_c);
  end

  assign bus.mapped_in_fifo_rd_req = accept_c;

  // Next-state: emit first, then append the compacted bits above what remains.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    wr_req_d     = 1'b0;
    wr_data_d    = wr_data_q;
    flush_done_d = 1'b0;
    acc_e        = acc_q;
    cnt_e        = cnt_q;

    if (emit_c || flush_emit_c) begin
      wr_req_d  = 1'b1;
      wr_data_d = acc_q[P-1:0];
      acc_e     = acc_q >> P;
      // A flushed partial word leaves nothing behind.
      cnt_e     = have_word_c ? (cnt_q - CW'(P)) : '0;
    end

    acc_d = acc_e;
    cnt_d = cnt_e;
    if (accept_c) begin
      acc_d = acc_e | (AW'(comp_c) << cnt_e);
      cnt_d = cnt_e + CW'(comp_k);
    end

    case (state_q)
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          flush_done_d = 1'b1;
          state_d      = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      wr_req_q     <= 1'b0;
      wr_data_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      wr_req_q     <= wr_req_d;
      wr_data_q    <= wr_data_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.data_out_fifo_wr_req  = wr_req_q;
  assign bus.data_out_fifo_wr_data = wr_data_q;
  assign bus.flush_done            = flush_done_q;

endmodule

// File: tb/tb_information_demapper.sv
// Bench for information_demapper: directed scenarios followed by random traffic,
// all checked against a bit-queue reference model of the demapper.
module tb_information_demapper;

  localparam int unsigned P = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  information_demapper_if #(.MAPPER_PARALLELISM(P)) bus ();

  information_demapper #(.MAPPER_PARALLELISM(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending information bits in arrival order, plus flush mode.
  bit mq[$];
  bit m_flushing = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [P-1:0] d, input logic [P-1:0] ind,
                       input logic empty, input logic full, input logic fl);
    bus.mapped_in_fifo_rd_data = d;
    bus.mapping_indicators     = ind;
    bus.mapped_in_fifo_empty   = empty;
    bus.data_out_fifo_full     = full;
    bus.flush                  = fl;
  endtask

  // One clock with current inputs: predict, check rd_req, clock, check outputs.
  task automatic run_cycle();
    int           cnt;
    bit           do_emit, do_part, do_acc, exp_done;
    logic [P-1:0] w, d, ind;
    cnt      = mq.size();
    d        = bus.mapped_in_fifo_rd_data;
    ind      = bus.mapping_indicators;
    do_emit  = (cnt >= int'(P)) && !bus.data_out_fifo_full;
    do_part  = m_flushing && (cnt > 0) && (cnt < int'(P)) && !bus.data_out_fifo_full;
    do_acc   = !m_flushing && !bus.mapped_in_fifo_empty && ((cnt < int'(P)) || do_emit);
    exp_done = m_flushing && (cnt == 0);
    #1;
    check("rd_req", 32'(bus.mapped_in_fifo_rd_req), 32'(do_acc));
    w = '0;
    if (do_emit || do_part) begin
      for (int i = 0; i < int'(P); i++) begin
        if (mq.size() > 0) w[i] = mq.pop_front();
      end
    end
    if (do_acc) begin
      for (int i = 0; i < int'(P); i++) begin
        if (ind[i]) mq.push_back(d[i]);
      end
    end
    if (exp_done) m_flushing = 1'b0;
    else if (!m_flushing && bus.flush) m_flushing = 1'b1;
    @(posedge clk);
    #1;
    check("wr_req", 32'(bus.data_out_fifo_wr_req), 32'(do_emit || do_part));
    if (do_emit || do_part) check("wr_data", 32'(bus.data_out_fifo_wr_data), 32'(w));
    check("flush_done", 32'(bus.flush_done), 32'(exp_done));
    check("fill_count", 32'(dut.cnt_q), 32'(mq.size()));
  endtask

  // Assert reset for one cycle with a non-empty input FIFO.
  task automatic do_reset();
    drive(8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_wr_req", 32'(bus.data_out_fifo_wr_req), 32'd0);
    check("rst_wr_data", 32'(bus.data_out_fifo_wr_data), 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);
    check("rst_rd_req", 32'(bus.mapped_in_fifo_rd_req), 32'd0);
    mq.delete();
    m_flushing = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    #2;
    do_reset();

    // 1: full-indicator words pass straight through.
    drive(8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0); run_cycle();
    check("t1_no_wr_first", 32'(bus.data_out_fifo_wr_req), 32'd0);
    drive(8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0); run_cycle();
    check("t1_wr_a5", 32'(bus.data_out_fifo_wr_data), 32'hA5);
    drive(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0); run_cycle();
    check("t1_wr_3c", 32'(bus.data_out_fifo_wr_data), 32'h3C);

    // 2: two nibbles combine into one word.
    drive(8'h5B, 8'h0F, 1'b0, 1'b0, 1'b0); run_cycle();
    check("t2_no_wr", 32'(bus.data_out_fifo_wr_req), 32'd0);
    drive(8'h97, 8'h0F, 1'b0, 1'b0, 1'b0); run_cycle();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); run_cycle();
    check("t2_wr_req", 32'(bus.data_out_fifo_wr_req), 32'd1);
    check("t2_wr_7b", 32'(bus.data_out_fifo_wr_data), 32'h7B);

    // 3: empty indicator words are popped but add nothing.
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom), 8'h00, 1'b0, 1'b0, 1'b0); run_cycle();
      check("t3_no_wr", 32'(bus.data_out_fifo_wr_req), 32'd0);
    end

    // 4: output full stalls input; release drains.
    drive(8'h11, 8'hFF, 1'b0, 1'b0, 1'b0); run_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(8'h22, 8'hFF, 1'b0, 1'b1, 1'b0); run_cycle();
      check("t4_stall_no_wr", 32'(bus.data_out_fifo_wr_req), 32'd0);
    end
    drive(8'h22, 8'hFF, 1'b0, 1'b0, 1'b0); run_cycle();
    check("t4_wr_11", 32'(bus.data_out_fifo_wr_data), 32'h11);
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); run_cycle();
    check("t4_wr_22", 32'(bus.data_out_fifo_wr_data), 32'h22);

    // 5: flush a 3-bit partial word.
    drive(8'h05, 8'h07, 1'b0, 1'b0, 1'b0); run_cycle();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); run_cycle();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); run_cycle();
    check("t5_wr_05", 32'(bus.data_out_fifo_wr_data), 32'h05);
    check("t5_wr_req", 32'(bus.data_out_fifo_wr_req), 32'd1);
    run_cycle();
    check("t5_done", 32'(bus.flush_done), 32'd1);
    run_cycle();
    check("t5_done_once", 32'(bus.flush_done), 32'd0);

    // Flush with nothing pending: done without a write.
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); run_cycle();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); run_cycle();
    check("t5b_done_no_wr", 32'({bus.flush_done, bus.data_out_fifo_wr_req}), 32'b10);

    // 6: reset mid-frame discards the partial word.
    drive(8'hFF, 8'h1F, 1'b0, 1'b0, 1'b0); run_cycle();
    check("t6_cnt5", 32'(dut.cnt_q), 32'd5);
    do_reset();
    drive(8'hC3, 8'hFF, 1'b0, 1'b0, 1'b0); run_cycle();
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); run_cycle();
    check("t6_wr_c3", 32'(bus.data_out_fifo_wr_data), 32'hC3);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      drive(8'($urandom), 8'($urandom), 1'($urandom_range(3) == 0),
            1'($urandom_range(3) == 0), 1'($urandom_range(15) == 0));
      run_cycle();
    end

    // Drain whatever is left.
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b1); run_cycle();
    for (int c = 0; c < 8; c++) begin
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0); run_cycle();
    end
    check("drain_empty", 32'(dut.cnt_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
